gpio_edge_debouncer: RTL and testbench

GPIO_EDGE_DEBOUNCER -- requirements
Module: gpio_edge_debouncer

---
 rtl/gpio_edge_debouncer.sv | 113 +++++++++++
 tb/tb_gpio_edge_debouncer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_edge_debouncer.sv
// Per-channel GPIO synchroniser, debouncer and edge-event latch.
// Pads are input-only; each channel debounces against a shared limit.
module gpio_edge_debouncer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNTR_WIDTH = 22
) (
  input  logic                  aclk,
  input  logic                  areset,
  inout  wire  [DATA_WIDTH-1:0] gpio_data,
  input  logic [CNTR_WIDTH-1:0] cfg_limit,
  input  logic [DATA_WIDTH-1:0] cfg_invert,
  input  logic [DATA_WIDTH-1:0] cfg_rise_en,
  input  logic [DATA_WIDTH-1:0] cfg_fall_en,
  input  logic [DATA_WIDTH-1:0] evt_clear,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [DATA_WIDTH-1:0] rise,
  output logic [DATA_WIDTH-1:0] fall,
  output logic [DATA_WIDTH-1:0] evt_flags,
  output logic                  irq
);

  // The pad output driver is permanently disabled (T=1, I=0), so the
  // pads are only ever read here and never driven from this block.
  logic [DATA_WIDTH-1:0] sync1;
  logic [DATA_WIDTH-1:0] sync2;
  logic [DATA_WIDTH-1:0] samp;
  logic [1:0]            primed;

  logic [CNTR_WIDTH-1:0] cnt_q [DATA_WIDTH];
  logic [CNTR_WIDTH-1:0] cnt_n [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] dout_n;

  assign samp = sync2 ^ cfg_invert;

  // Two-flop synchroniser on every pad bit.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_data;
      sync2 <= sync1;
    end
  end

  // Counting waits until the synchroniser holds real pad data, so the
  // first debounce after reset sees the full pad-to-dout latency.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      primed <= '0;
    end else begin
      primed <= {primed[0], 1'b1};
    end
  end

  // Debounce decision per channel: restart, count, or toggle.
  always_comb begin
    dout_n = dout;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      cnt_n[i] = cnt_q[i];
      if (!primed[1]) begin
        cnt_n[i] = '0;
      end else if (samp[i] == dout[i]) begin
        cnt_n[i] = '0;
      end else if (cnt_q[i] < cfg_limit) begin
        cnt_n[i] = cnt_q[i] + CNTR_WIDTH'(1);
      end else begin
        cnt_n[i]  = '0;
        dout_n[i] = ~dout[i];
      end
    end
  end

  // Counter state; >= compare means it never wraps.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        cnt_q[i] <= cnt_n[i];
      end
    end
  end

  // Debounced level with edge pulses aligned to its first new cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      dout <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      dout <= dout_n;
      rise <= dout_n & ~dout;
      fall <= ~dout_n & dout;
    end
  end

  // Sticky event flags; a set in the same cycle as a clear wins.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      evt_flags <= '0;
    end else begin
      evt_flags <= (evt_flags & ~evt_clear)
                 | (rise & cfg_rise_en)
                 | (fall & cfg_fall_en);
    end
  end

  assign irq = |evt_flags;

endmodule

// File: tb/tb_gpio_edge_debouncer.sv
// Bench for gpio_edge_debouncer: directed scenarios plus random traffic
// compared each cycle against a sample-history reference model.
module tb_gpio_edge_debouncer;

  localparam int DW = 8;
  localparam int CW = 22;

  logic          aclk = 1'b0;
  logic          areset = 1'b0;
  logic [DW-1:0] pad;
  wire  [DW-1:0] gpio;
  logic [CW-1:0] lim;
  logic [DW-1:0] inv, ren, fen, clr;
  wire  [DW-1:0] dout, rise, fall, flags;
  wire           irq;

  assign gpio = pad;

  gpio_edge_debouncer #(.DATA_WIDTH(DW), .CNTR_WIDTH(CW)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .gpio_data   (gpio),
    .cfg_limit   (lim),
    .cfg_invert  (inv),
    .cfg_rise_en (ren),
    .cfg_fall_en (fen),
    .evt_clear   (clr),
    .dout        (dout),
    .rise        (rise),
    .fall        (fall),
    .evt_flags   (flags),
    .irq         (irq)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: remembers every pad value and every valid sample
  // since reset; dout flips once the trailing run of samples that
  // disagree with it exceeds the current limit.
  logic [DW-1:0] m_dout, m_rise, m_fall, m_flags;
  logic [DW-1:0] phist[$];
  logic [DW-1:0] shist[$];
  int            n;

  task automatic model_reset();
    m_dout = '0; m_rise = '0; m_fall = '0; m_flags = '0;
    phist.delete();
    shist.delete();
    n = 0;
  endtask

  task automatic step();
    logic [DW-1:0] p, iv, re, fe, c, nd, nf, sv;
    logic [CW-1:0] l;
    int run;
    p = pad; iv = inv; re = ren; fe = fen; c = clr; l = lim;
    @(posedge aclk);
    #1;
    n++;
    phist.push_back(p);
    nf = (m_flags & ~c) | (m_rise & re) | (m_fall & fe);
    nd = m_dout;
    if (n >= 3) begin
      sv = phist[n-3] ^ iv;
      shist.push_back(sv);
      for (int ch = 0; ch < DW; ch++) begin
        run = 0;
        for (int k = shist.size() - 1; k >= 0; k--) begin
          if (shist[k][ch] != m_dout[ch]) run++;
          else break;
          if (run > int'(l)) break;
        end
        if (run >= int'(l) + 1) nd[ch] = ~m_dout[ch];
      end
    end
    m_rise  = nd & ~m_dout;
    m_fall  = ~nd & m_dout;
    m_dout  = nd;
    m_flags = nf;
    check("dout", 32'(dout), 32'(m_dout));
    check("rise", 32'(rise), 32'(m_rise));
    check("fall", 32'(fall), 32'(m_fall));
    check("flags", 32'(flags), 32'(m_flags));
    check("irq", 32'(irq), 32'(|m_flags));
  endtask

  task automatic do_reset();
    areset = 1'b1;
    #1;
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_rise", 32'(rise), 32'h0);
    check("rst_fall", 32'(fall), 32'h0);
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    @(posedge aclk);
    #1;
    model_reset();
    areset = 1'b0;
  endtask

  task automatic setup(input logic [CW-1:0] l, input logic [DW-1:0] p,
                       input logic [DW-1:0] iv, input logic [DW-1:0] re,
                       input logic [DW-1:0] fe);
    lim = l; pad = p; inv = iv; ren = re; fen = fe; clr = '0;
    do_reset();
  endtask

  initial begin
    lim = '0; pad = '0; inv = '0; ren = '0; fen = '0; clr = '0;
    model_reset();
    #2;

    // 7-cycle pad-to-dout latency with limit 4
    setup(4, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (4) step();
    pad[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("lat_wait", 32'(dout[0]), 32'h0);
    end
    step();
    check("lat_dout", 32'(dout[0]), 32'h1);
    check("lat_rise", 32'(rise[0]), 32'h1);
    step();
    check("lat_pulse1", 32'(rise[0]), 32'h0);

    // one-cycle glitch restarts the count
    setup(4, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (4) step();
    pad[0] = 1'b1;
    repeat (4) step();
    pad[0] = 1'b0;
    step();
    pad[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("glitch_wait", 32'(dout[0]), 32'h0);
    end
    step();
    check("glitch_dout", 32'(dout[0]), 32'h1);

    // limit 0 fall event, flag, irq and clear
    setup(0, 8'h04, 8'h00, 8'h00, 8'h04);
    repeat (5) step();
    pad[2] = 1'b0;
    repeat (2) step();
    check("l0_hold", 32'(dout[2]), 32'h1);
    step();
    check("l0_fall", 32'(fall[2]), 32'h1);
    check("l0_dout", 32'(dout[2]), 32'h0);
    step();
    check("l0_flag", 32'(flags[2]), 32'h1);
    check("l0_irq", 32'(irq), 32'h1);
    clr[2] = 1'b1;
    step();
    clr[2] = 1'b0;
    check("clr_flag", 32'(flags[2]), 32'h0);
    check("clr_irq", 32'(irq), 32'h0);

    // set wins over a held clear
    setup(0, 8'h00, 8'h00, 8'h02, 8'h00);
    clr = 8'h02;
    repeat (3) step();
    pad[1] = 1'b1;
    repeat (3) step();
    check("sw_rise", 32'(rise[1]), 32'h1);
    step();
    check("sw_flag", 32'(flags[1]), 32'h1);
    clr = '0;

    // inverted channel debounces to 1 out of reset
    setup(2, 8'h00, 8'h08, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      check("inv_wait", 32'(dout[3]), 32'h0);
    end
    step();
    check("inv_dout", 32'(dout[3]), 32'h1);
    check("inv_rise", 32'(rise[3]), 32'h1);

    // lowering the limit below the running count toggles at once
    setup(10, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) step();
    pad[0] = 1'b1;
    repeat (8) step();
    check("low_wait", 32'(dout[0]), 32'h0);
    lim = 2;
    step();
    check("low_dout", 32'(dout[0]), 32'h1);

    // reset mid-count on every channel, then a fresh full count
    setup(6, 8'h00, 8'h00, 8'hff, 8'hff);
    repeat (3) step();
    pad = 8'hff;
    repeat (4) step();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      check("mid_rise", 32'(rise), 32'h0);
    end
    step();
    check("mid_dout", 32'(dout), 32'hff);
    check("mid_rise9", 32'(rise), 32'hff);

    // random traffic against the model
    for (int b = 0; b < 4; b++) begin
      setup(CW'($urandom_range(0, 5)), 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom));
      for (int i = 0; i < 250; i++) begin
        pad = pad ^ 8'($urandom & $urandom & $urandom);
        clr = 8'($urandom & $urandom & $urandom);
        if ($urandom_range(0, 31) == 0) inv = inv ^ 8'(1 << $urandom_range(0, 7));
        if ($urandom_range(0, 49) == 0) lim = CW'($urandom_range(0, 5));
        if (i == 125) do_reset();
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
